operand_bank_arbiter: RTL and testbench

//  Register-file read front end for the operand collector stage: 32 x DATA_W regs split into
//  4 banks by reg_id[4:3]. Per-bank round-robin arbitration of operand read requests from
//  2*N_OC source slots (slot = oc_index*2 + src). Drives each bank's result bus
//  (data/vld/ocid/bz) to every collector unit; a collector latches data when ocid matches its

---
 rtl/operand_bank_arbiter.sv | 95 +++++++++
 tb/tb_operand_bank_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bank_arbiter.sv
// Operand-collector register file front end: 4 banks of 8 registers, with a per-bank
// round-robin read arbiter. Write-back has priority over reads, and results go out on registered bank buses.
module operand_bank_arbiter #(
    parameter int N_OC   = 2,
    parameter int DATA_W = 32,
    parameter int SLOT_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*N_OC-1:0]     req_vld,
    input  logic [2*N_OC*5-1:0]   req_reg_id,
    output logic [2*N_OC-1:0]     req_gnt,
    input  logic                  wb_en,
    input  logic [4:0]            wb_reg_id,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [4*DATA_W-1:0]   bk_data,
    output logic [3:0]            bk_vld,
    output logic [4*SLOT_W-1:0]   bk_ocid,
    output logic [3:0]            bk_bz
);

    localparam int NS = 2 * N_OC;

    logic [DATA_W-1:0] regs [32];
    logic [SLOT_W-1:0] ptr [4];
    logic [3:0]        wb_hit;
    logic [3:0]        win_vld;
    logic [SLOT_W-1:0] win_slot [4];
    logic [4:0]        win_id [4];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wb_hit[b] = wb_en && (wb_reg_id[4:3] == 2'(b));
        end
    end

    // A bank that is taking a write-back grants nothing.
    // Slots are scanned upward from the pointer and wrap at NS.
    always_comb begin
        int idx;
        idx     = 0;
        req_gnt = '0;
        win_vld = '0;
        for (int b = 0; b < 4; b++) begin
            win_slot[b] = '0;
            win_id[b]   = '0;
        end
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                if (!wb_hit[b]) begin
                    for (int k = 0; k < NS; k++) begin
                        idx = (int'(ptr[b]) + k) % NS;
                        if (!win_vld[b] && req_vld[idx] &&
                            (req_reg_id[idx*5+3 +: 2] == 2'(b))) begin
                            win_vld[b]   = 1'b1;
                            win_slot[b]  = SLOT_W'(idx);
                            win_id[b]    = req_reg_id[idx*5 +: 5];
                            req_gnt[idx] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int b = 0; b < 4; b++) ptr[b] <= '0;
            bk_data <= '0;
            bk_vld  <= '0;
            bk_ocid <= '0;
            bk_bz   <= '0;
        end else begin
            if (wb_en) regs[wb_reg_id] <= wb_data;
            for (int b = 0; b < 4; b++) begin
                if (wb_hit[b]) begin
                    bk_bz[b]  <= 1'b1;
                    bk_vld[b] <= 1'b0;
                end else if (win_vld[b]) begin
                    // Reads use the pre-edge value; a same-edge write cannot target this bank.
                    bk_data[b*DATA_W +: DATA_W] <= regs[win_id[b]];
                    bk_ocid[b*SLOT_W +: SLOT_W] <= win_slot[b];
                    bk_vld[b] <= 1'b1;
                    bk_bz[b]  <= 1'b0;
                    ptr[b]    <= SLOT_W'((int'(win_slot[b]) + 1) % NS);
                end else begin
                    bk_vld[b] <= 1'b0;
                    bk_bz[b]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_bank_arbiter.sv
// Directed bench for operand_bank_arbiter with N_OC=2 (4 slots, 2-bit ocid).
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
module tb_operand_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_vld = '0;
    logic [19:0] req_reg_id = '0;
    logic [3:0]  req_gnt;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg_id = '0;
    logic [31:0] wb_data = '0;
    logic [127:0] bk_data;
    logic [3:0]  bk_vld;
    logic [7:0]  bk_ocid;
    logic [3:0]  bk_bz;

    int tests = 0;
    int fails = 0;

    operand_bank_arbiter #(.N_OC(2), .DATA_W(32), .SLOT_W(2)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_reg_id(req_reg_id),
        .req_gnt(req_gnt), .wb_en(wb_en), .wb_reg_id(wb_reg_id), .wb_data(wb_data),
        .bk_data(bk_data), .bk_vld(bk_vld), .bk_ocid(bk_ocid), .bk_bz(bk_bz)
    );

    always #5 clk = ~clk;

    task automatic set_id(input int s, input logic [4:0] id);
        req_reg_id[s*5 +: 5] = id;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        set_id(0, 5'd0); set_id(1, 5'd8); set_id(2, 5'd16); set_id(3, 5'd24);
        req_vld = 4'b1111;
        #12;
        tests++;
        if (req_gnt !== 4'b0000) begin
            fails++; $display("FAIL reset_gnt: got %b expected 0000", req_gnt);
        end
        tests++;
        if (bk_vld !== 4'b0000 || bk_bz !== 4'b0000 || bk_data !== '0 || bk_ocid !== '0) begin
            fails++; $display("FAIL reset_outputs: vld=%b bz=%b ocid=%h data=%h expected all zero",
                              bk_vld, bk_bz, bk_ocid, bk_data);
        end
        @(negedge clk);
        rst = 1'b0;
        req_vld = '0;
    endtask

    task automatic test_wb_read();
        @(negedge clk);
        wb_en = 1'b1; wb_reg_id = 5'd9; wb_data = 32'hDEADBEEF;
        step();
        tests++;
        if (bk_bz !== 4'b0010 || bk_vld !== 4'b0000) begin
            fails++; $display("FAIL wb_bz: bz=%b vld=%b expected bz=0010 vld=0000", bk_bz, bk_vld);
        end
        @(negedge clk);
        wb_en = 1'b0; set_id(0, 5'd9); req_vld = 4'b0001;
        #1;
        tests++;
        if (req_gnt !== 4'b0001) begin
            fails++; $display("FAIL read_gnt: got %b expected 0001", req_gnt);
        end
        step();
        tests++;
        if (bk_vld !== 4'b0010 || bk_data[32 +: 32] !== 32'hDEADBEEF || bk_ocid[2 +: 2] !== 2'd0) begin
            fails++; $display("FAIL read_r9: vld=%b data=%h ocid=%0d expected 0010 deadbeef 0",
                              bk_vld, bk_data[32 +: 32], bk_ocid[2 +: 2]);
        end
        @(negedge clk);
        req_vld = '0;
        step();
        tests++;
        if (bk_vld !== 4'b0000) begin
            fails++; $display("FAIL vld_pulse: got %b expected 0000", bk_vld);
        end
    endtask

    task automatic test_rr_bank2();
        logic [3:0] exp_gnt [3];
        logic [1:0] exp_oc [3];
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b1000;
        exp_oc[0]  = 2'd0;    exp_oc[1]  = 2'd1;    exp_oc[2]  = 2'd3;
        @(negedge clk);
        set_id(0, 5'd16); set_id(1, 5'd20); set_id(3, 5'd23);
        req_vld = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (req_gnt !== exp_gnt[i]) begin
                fails++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, req_gnt, exp_gnt[i]);
            end
            step();
            tests++;
            if (bk_vld !== 4'b0100 || bk_ocid[4 +: 2] !== exp_oc[i]) begin
                fails++; $display("FAIL rr_ocid[%0d]: vld=%b ocid=%0d expected 0100 %0d",
                                  i, bk_vld, bk_ocid[4 +: 2], exp_oc[i]);
            end
            @(negedge clk);
            req_vld = req_vld & ~exp_gnt[i];
        end
        // Pointer wrapped back to 0: slot 0 must beat slot 3.
        req_vld = 4'b1001;
        #1;
        tests++;
        if (req_gnt !== 4'b0001) begin
            fails++; $display("FAIL rr_wrap: got %b expected 0001", req_gnt);
        end
        step();
        @(negedge clk);
        req_vld = 4'b1000;
        #1;
        tests++;
        if (req_gnt !== 4'b1000) begin
            fails++; $display("FAIL rr_wrap_next: got %b expected 1000", req_gnt);
        end
        step();
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_all_banks(input string tag);
        @(negedge clk);
        set_id(0, 5'd1); set_id(1, 5'd9); set_id(2, 5'd17); set_id(3, 5'd25);
        req_vld = 4'b1111;
        #1;
        tests++;
        if (req_gnt !== 4'b1111) begin
            fails++; $display("FAIL %s_gnt: got %b expected 1111", tag, req_gnt);
        end
        step();
        tests++;
        if (bk_vld !== 4'b1111 || bk_ocid !== 8'he4 || bk_data[32 +: 32] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL %s_bus: vld=%b ocid=%h data1=%h expected 1111 e4 deadbeef",
                              tag, bk_vld, bk_ocid, bk_data[32 +: 32]);
        end
    endtask

    task automatic test_wb_conflict();
        @(negedge clk);
        req_vld = '0;
        wb_en = 1'b1; wb_reg_id = 5'd4; wb_data = 32'h0000_1234;
        set_id(2, 5'd5); req_vld = 4'b0100;
        #1;
        tests++;
        if (req_gnt !== 4'b0000) begin
            fails++; $display("FAIL conflict_gnt: got %b expected 0000", req_gnt);
        end
        step();
        tests++;
        if (bk_bz[0] !== 1'b1 || bk_vld[0] !== 1'b0) begin
            fails++; $display("FAIL conflict_bz: bz=%b vld=%b expected bz[0]=1 vld[0]=0", bk_bz, bk_vld);
        end
        @(negedge clk);
        wb_en = 1'b0;
        #1;
        tests++;
        if (req_gnt !== 4'b0100) begin
            fails++; $display("FAIL retry_gnt: got %b expected 0100", req_gnt);
        end
        step();
        tests++;
        if (bk_vld !== 4'b0001 || bk_bz !== 4'b0000 || bk_ocid[0 +: 2] !== 2'd2 || bk_data[0 +: 32] !== 32'h0) begin
            fails++; $display("FAIL retry_bus: vld=%b bz=%b ocid=%0d data=%h expected 0001 0000 2 0",
                              bk_vld, bk_bz, bk_ocid[0 +: 2], bk_data[0 +: 32]);
        end
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_raw();
        @(negedge clk);
        wb_en = 1'b1; wb_reg_id = 5'd12; wb_data = 32'h5;
        step();
        @(negedge clk);
        wb_en = 1'b0; set_id(1, 5'd12); req_vld = 4'b0010;
        #1;
        tests++;
        if (req_gnt !== 4'b0010) begin
            fails++; $display("FAIL raw_gnt: got %b expected 0010", req_gnt);
        end
        step();
        tests++;
        if (bk_vld !== 4'b0010 || bk_data[32 +: 32] !== 32'h5 || bk_ocid[2 +: 2] !== 2'd1) begin
            fails++; $display("FAIL raw_data: vld=%b data=%h ocid=%0d expected 0010 5 1",
                              bk_vld, bk_data[32 +: 32], bk_ocid[2 +: 2]);
        end
        @(negedge clk);
        req_vld = '0;
    endtask

    task automatic test_async_reset();
        test_all_banks("prerst");
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bk_vld !== 4'b0000 || bk_bz !== 4'b0000 || bk_data !== '0 || bk_ocid !== '0) begin
            fails++; $display("FAIL async_clear: vld=%b bz=%b ocid=%h data=%h expected all zero",
                              bk_vld, bk_bz, bk_ocid, bk_data);
        end
        tests++;
        if (req_gnt !== 4'b0000) begin
            fails++; $display("FAIL async_gnt: got %b expected 0000", req_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        set_id(0, 5'd9); set_id(2, 5'd10); req_vld = 4'b0101;
        #1;
        tests++;
        if (req_gnt !== 4'b0001) begin
            fails++; $display("FAIL post_rst_ptr: got %b expected 0001", req_gnt);
        end
        step();
        tests++;
        if (bk_vld !== 4'b0010 || bk_data[32 +: 32] !== 32'h0 || bk_ocid[2 +: 2] !== 2'd0) begin
            fails++; $display("FAIL post_rst_reg: vld=%b data=%h ocid=%0d expected 0010 0 0",
                              bk_vld, bk_data[32 +: 32], bk_ocid[2 +: 2]);
        end
        @(negedge clk);
        req_vld = '0;
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_rr_bank2();
        test_all_banks("all4");
        test_wb_conflict();
        test_raw();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
